// File: rtl/cpu_register_file.sv
// Parametrised CPU register file: one write port, two registered read ports with
// write-forwarding, optional hardwired zero register and a written-since-reset mask.
module cpu_register_file #(
  parameter int NrOfBits = 8,
  parameter int NrOfRegs = 4,
  parameter int AddrBits = 2,
  parameter int ZeroReg  = 0
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                ClockEnable,
  input  logic                WriteEnable,
  input  logic [AddrBits-1:0] WriteAddr,
  input  logic [NrOfBits-1:0] WriteData,
  input  logic [AddrBits-1:0] ReadAddrA,
  input  logic [AddrBits-1:0] ReadAddrB,
  output logic [NrOfBits-1:0] ReadDataA,
  output logic [NrOfBits-1:0] ReadDataB,
  output logic [NrOfRegs-1:0] ValidMask
);

  localparam bit HasZeroReg = (ZeroReg != 0);

  logic                w_addr_is_zero;
  logic                w_write_ok;
  logic [NrOfRegs-1:0] w_wr_sel;
  logic [NrOfBits-1:0] w_reg_val [NrOfRegs];
  logic                w_fwd_a;
  logic                w_fwd_b;
  logic [NrOfBits-1:0] w_next_a;
  logic [NrOfBits-1:0] w_next_b;
  logic [NrOfBits-1:0] r_read_a;
  logic [NrOfBits-1:0] r_read_b;
  logic [NrOfRegs-1:0] r_valid;

  // A write aimed at the hardwired zero register is squashed here, which also
  // kills the forward path for it.
  assign w_addr_is_zero = (WriteAddr == '0);
  assign w_write_ok     = WriteEnable && !(HasZeroReg && w_addr_is_zero);

  generate
    for (genvar gi = 0; gi < NrOfRegs; gi++) begin : g_reg
      localparam bit IsZero = HasZeroReg && (gi == 0);
      logic [NrOfBits-1:0] r_q;

      assign w_wr_sel[gi] = w_write_ok && (WriteAddr == AddrBits'(gi));

      always_ff @(posedge Clock) begin
        if (Reset) begin
          r_q <= '0;
        end else if (ClockEnable && w_wr_sel[gi] && !IsZero) begin
          r_q <= WriteData;
        end
      end

      assign w_reg_val[gi] = IsZero ? '0 : r_q;

      always_ff @(posedge Clock) begin
        if (Reset) begin
          r_valid[gi] <= 1'b0;
        end else if (ClockEnable && (w_wr_sel[gi] || IsZero)) begin
          r_valid[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  assign w_fwd_a  = w_write_ok && (WriteAddr == ReadAddrA);
  assign w_fwd_b  = w_write_ok && (WriteAddr == ReadAddrB);
  assign w_next_a = w_fwd_a ? WriteData : w_reg_val[ReadAddrA];
  assign w_next_b = w_fwd_b ? WriteData : w_reg_val[ReadAddrB];

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_read_a <= '0;
      r_read_b <= '0;
    end else if (ClockEnable) begin
      r_read_a <= w_next_a;
      r_read_b <= w_next_b;
    end
  end

  assign ReadDataA = r_read_a;
  assign ReadDataB = r_read_b;
  assign ValidMask = r_valid;

endmodule

// File: doc/cpu_register_file.md
Name: cpu_register_file

Overview:
Parametrised multi-register storage block for the CPU datapath. It generalises the fixed 2-bit clocked register into NrOfRegs registers of NrOfBits width. It provides one write port, two registered read ports with write-forwarding, an optional hardwired zero register, and a per-register "written since reset" valid mask. It sits between the instruction decoder and the ALU, and supplies both ALU operands each cycle.

Parameters:
NrOfBits, 8, width of every register and data port (1..32)
NrOfRegs, 4, number of registers (2..16); must equal 2**AddrBits
AddrBits, 2, address width of all address ports
ZeroReg, 0, when 1 register 0 always reads 0 and ignores writes

Ports:
Clock  input  1  single system clock, all state updates on rising edge
Reset  input  1  synchronous, active-high reset
ClockEnable  input  1  when 0 the block holds all state and outputs
WriteEnable  input  1  write WriteData into register WriteAddr this cycle
WriteAddr  input  AddrBits  destination register index
WriteData  input  NrOfBits  data to write
ReadAddrA  input  AddrBits  operand A register index
ReadAddrB  input  AddrBits  operand B register index
ReadDataA  output  NrOfBits  registered contents for ReadAddrA, 1-cycle latency
ReadDataB  output  NrOfBits  registered contents for ReadAddrB, 1-cycle latency
ValidMask  output  NrOfRegs  bit i = 1 once register i has been written since reset

Behaviour:
- Reset is synchronous and active-high. Reset on the rising edge of Clock has priority over ClockEnable and over all other inputs.
- Reset clears all registers to 0, ReadDataA/B to 0 and ValidMask to 0. Outputs read 0 in the cycle after the reset edge.
- Reset asserted mid-write: the write is discarded and the register stays 0.
- ClockEnable=0: no register, output or mask change; WriteEnable is ignored.
- Write: on an edge with ClockEnable=1 and WriteEnable=1, reg[WriteAddr] <= WriteData and ValidMask[WriteAddr] <= 1.
- Read: on every enabled edge, ReadDataA <= value of reg[ReadAddrA]; likewise for B. The result is visible one cycle after the address is presented.
- Forwarding: if WriteEnable=1 and WriteAddr==ReadAddrA on the same enabled edge, ReadDataA <= WriteData (the new value, not the old one). The same rule applies independently to port B.
- Both read ports may address the same register, including the register being written; both then return the same value.
- ZeroReg=1:
  - Writes to address 0 are dropped; this includes the forward path, so a read of 0 returns 0.
  - ValidMask[0] is held at 1 after reset completes.
  - ReadData for address 0 is always 0.
- ZeroReg=0: register 0 behaves like every other register.
- Addresses are always in range by construction (NrOfRegs = 2**AddrBits); no out-of-range handling is required.
- Data is stored unmodified; no arithmetic is performed and no width conversion is applied.
- There is no internal state machine beyond storage. The only state is the register array, the two output registers and ValidMask.

Test Plan:
- Reset, then idle 2 cycles with ReadAddrA=1, ReadAddrB=3 -> ReadDataA=0, ReadDataB=0, ValidMask=4'b0000 (NrOfBits=8, NrOfRegs=4).
- Write 8'hA5 to reg 2 on cycle N, then ReadAddrA=2 on cycle N+1 -> ReadDataA=8'hA5 after edge N+1 and ValidMask=4'b0100 after edge N.
- Same-cycle forward: reg 1 holds 8'h11; present WriteAddr=1, WriteData=8'h22, ReadAddrA=1, ReadAddrB=1 on one edge -> after that edge ReadDataA=8'h22 and ReadDataB=8'h22.
- ClockEnable=0 with WriteEnable=1, WriteAddr=3, WriteData=8'hFF for 3 cycles -> reg 3 unchanged (0), ReadData unchanged, ValidMask[3]=0; raise ClockEnable and read reg 3 -> 8'h00.
- ZeroReg=1: write 8'h7E to reg 0 while reading address 0 on both ports -> ReadDataA=ReadDataB=0 on that edge and every later edge; ValidMask[0]=1.
- Reset asserted together with WriteEnable=1, WriteAddr=0, WriteData=8'h33 after regs are loaded with nonzero values -> all regs read 0 on later reads and ValidMask=0 (ZeroReg=0).
